// File: rtl/srl_fifo_af.sv
// Shift-register FIFO with registered full/empty/almost-full flags, an occupancy count
// and an optional registered output stage (DOUT_REG=1 adds one entry of capacity).
module srl_fifo_af #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 1,
    parameter int DEPTH      = 2,
    parameter int DOUT_REG   = 0,
    parameter int AF_MARGIN  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_full_n,
    output logic                  almost_full_n,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic                  if_empty_n,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic [ADDR_WIDTH+1:0] if_num_data_valid
);

    localparam int CAPACITY = DEPTH + ((DOUT_REG != 0) ? 1 : 0);
    localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   SRL_ONE = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH+1:0] TOT_ONE = (ADDR_WIDTH+2)'(1);

    logic [DATA_WIDTH-1:0] srl_mem [DEPTH];
    logic [ADDR_WIDTH:0]   srl_count, srl_count_next;
    logic [ADDR_WIDTH+1:0] total, total_next;
    logic [ADDR_WIDTH-1:0] head_idx;
    logic [DATA_WIDTH-1:0] head_data;
    logic                  push, pop, srl_push, srl_pop;
    logic                  full_n_q, af_n_q, empty_n_q, empty_n_next;

    assign push     = if_write_ce & if_write & full_n_q;
    assign pop      = if_read_ce & if_read & empty_n_q;
    assign srl_push = push;

    // Newest entry sits at index 0, so the head is the oldest valid slot.
    assign head_idx  = (srl_count == '0) ? '0 : ADDR_WIDTH'(srl_count - SRL_ONE);
    assign head_data = srl_mem[head_idx];

    generate
        if (DOUT_REG != 0) begin : g_oreg
            logic                  ov, ov_next;
            logic [DATA_WIDTH-1:0] oreg;

            // Refill the output register whenever it is empty or being consumed.
            assign srl_pop = (~ov | pop) & (srl_count != '0);

            always_comb begin
                ov_next = ov;
                if (srl_pop)
                    ov_next = 1'b1;
                else if (pop)
                    ov_next = 1'b0;
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    ov   <= 1'b0;
                    oreg <= '0;
                end else begin
                    ov <= ov_next;
                    if (srl_pop)
                        oreg <= head_data;
                end
            end

            assign empty_n_next = ov_next;
            assign if_dout      = oreg;
        end else begin : g_comb
            assign srl_pop      = pop;
            assign empty_n_next = (total_next != '0);
            assign if_dout      = head_data;
        end
    endgenerate

    always_comb begin
        total_next = total;
        case ({push, pop})
            2'b10:   total_next = total + TOT_ONE;
            2'b01:   total_next = total - TOT_ONE;
            default: total_next = total;
        endcase
        srl_count_next = srl_count;
        case ({srl_push, srl_pop})
            2'b10:   srl_count_next = srl_count + SRL_ONE;
            2'b01:   srl_count_next = srl_count - SRL_ONE;
            default: srl_count_next = srl_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset && srl_push) begin
            for (int i = DEPTH - 1; i > 0; i--)
                srl_mem[i] <= srl_mem[i-1];
            srl_mem[0] <= if_din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            srl_count <= '0;
            total     <= '0;
            full_n_q  <= 1'b1;
            af_n_q    <= 1'b1;
            empty_n_q <= 1'b0;
        end else begin
            srl_count <= srl_count_next;
            total     <= total_next;
            full_n_q  <= (srl_count_next < DEPTH_C);
            af_n_q    <= ((CAPACITY - int'(total_next)) > AF_MARGIN);
            empty_n_q <= empty_n_next;
        end
    end

    assign if_full_n         = full_n_q;
    assign almost_full_n     = af_n_q;
    assign if_empty_n        = empty_n_q;
    assign if_num_data_valid = total;

endmodule

// File: tb/tb_srl_fifo_af.sv
// Scoreboard bench: one combinational-read FIFO and one output-registered FIFO, both DEPTH=4.
module tb_srl_fifo_af;

    localparam int DW  = 8;
    localparam int AW  = 2;
    localparam int DEP = 4;
    localparam int AFM = 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic          w0_ce = 0, w0 = 0, r0_ce = 0, r0 = 0;
    logic [DW-1:0] din0 = '0, dout0;
    logic          full_n0, af_n0, empty_n0;
    logic [AW+1:0] cnt0;

    logic          w1_ce = 0, w1 = 0, r1_ce = 0, r1 = 0;
    logic [DW-1:0] din1 = '0, dout1;
    logic          full_n1, af_n1, empty_n1;
    logic [AW+1:0] cnt1;

    int total = 0;
    int bad = 0;
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];

    srl_fifo_af #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEP), .DOUT_REG(0), .AF_MARGIN(AFM)) u_dut0 (
        .clk(clk), .reset(reset),
        .if_write_ce(w0_ce), .if_write(w0), .if_din(din0),
        .if_full_n(full_n0), .almost_full_n(af_n0),
        .if_read_ce(r0_ce), .if_read(r0),
        .if_empty_n(empty_n0), .if_dout(dout0), .if_num_data_valid(cnt0)
    );

    srl_fifo_af #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEP), .DOUT_REG(1), .AF_MARGIN(AFM)) u_dut1 (
        .clk(clk), .reset(reset),
        .if_write_ce(w1_ce), .if_write(w1), .if_din(din1),
        .if_full_n(full_n1), .almost_full_n(af_n1),
        .if_read_ce(r1_ce), .if_read(r1),
        .if_empty_n(empty_n1), .if_dout(dout1), .if_num_data_valid(cnt1)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted pop is matched against the oldest expected word.
    always @(negedge clk) begin
        if (!reset && r0_ce && r0 && empty_n0) begin
            if (q0.size() == 0) begin
                total++; bad++;
                $display("FAIL dout0_unexpected: got %0h expected no data", dout0);
            end else
                check("dout0", int'(dout0), int'(q0.pop_front()));
        end
        if (!reset && r1_ce && r1 && empty_n1) begin
            if (q1.size() == 0) begin
                total++; bad++;
                $display("FAIL dout1_unexpected: got %0h expected no data", dout1);
            end else
                check("dout1", int'(dout1), int'(q1.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] dat [4];
        int stalls, maxc;
        dat = '{8'hA, 8'hB, 8'hC, 8'hD};

        tick(); tick();
        reset = 1'b0;
        check("rst_empty_n0", int'(empty_n0), 0);
        check("rst_full_n0", int'(full_n0), 1);
        check("rst_af_n0", int'(af_n0), 1);
        check("rst_cnt0", int'(cnt0), 0);
        check("rst_empty_n1", int'(empty_n1), 0);
        check("rst_full_n1", int'(full_n1), 1);
        check("rst_cnt1", int'(cnt1), 0);

        // Mode 0: fill to full
        for (int i = 0; i < 4; i++) begin
            w0_ce = 1; w0 = 1; din0 = dat[i]; q0.push_back(dat[i]);
            tick();
            if (i == 1) check("af0_after2", int'(af_n0), 1);
            if (i == 2) begin
                check("af0_after3", int'(af_n0), 0);
                check("full0_after3", int'(full_n0), 1);
            end
        end
        w0 = 0;
        check("full0_after4", int'(full_n0), 0);
        check("cnt0_full", int'(cnt0), 4);
        check("empty_n0_full", int'(empty_n0), 1);

        w0 = 1; din0 = 8'hEE;
        tick();
        w0 = 0;
        check("cnt0_wr_full", int'(cnt0), 4);

        // Full + read + write: only the pop is taken
        r0_ce = 1; r0 = 1; w0 = 1; din0 = 8'h9;
        tick();
        check("cnt0_rw_full", int'(cnt0), 3);
        check("full0_rw_full", int'(full_n0), 1);
        q0.push_back(8'h9);
        tick();
        check("cnt0_rw_steady", int'(cnt0), 3);
        w0 = 0;
        tick(); tick(); tick();
        r0 = 0;
        check("empty_n0_drain", int'(empty_n0), 0);
        check("cnt0_drain", int'(cnt0), 0);

        r0 = 1;
        tick();
        r0 = 0;
        check("cnt0_rd_empty", int'(cnt0), 0);
        check("empty_n0_rd_empty", int'(empty_n0), 0);

        w0_ce = 0; w0 = 1; din0 = 8'h66;
        tick();
        w0 = 0;
        check("cnt0_ce_low", int'(cnt0), 0);
        check("empty_n0_ce_low", int'(empty_n0), 0);

        // Mode 1: ordering and capacity DEPTH+1
        for (int i = 1; i <= 5; i++) begin
            w1_ce = 1; w1 = 1; din1 = 8'(i); q1.push_back(8'(i));
            tick();
            if (i == 3) check("af1_after3", int'(af_n1), 1);
            if (i == 4) begin
                check("af1_after4", int'(af_n1), 0);
                check("full1_after4", int'(full_n1), 1);
            end
        end
        w1 = 0;
        check("full1_after5", int'(full_n1), 0);
        check("cnt1_full", int'(cnt1), 5);
        check("empty_n1_full", int'(empty_n1), 1);

        w1 = 1; din1 = 8'hEE;
        tick();
        w1 = 0;
        check("cnt1_wr_full", int'(cnt1), 5);

        r1_ce = 1; r1 = 1;
        repeat (5) tick();
        r1 = 0;
        check("empty_n1_drain", int'(empty_n1), 0);
        check("cnt1_drain", int'(cnt1), 0);

        // Mode 1 streaming
        stalls = 0; maxc = 0;
        for (int i = 0; i < 100; i++) begin
            w1_ce = 1; w1 = 1; din1 = 8'(i); q1.push_back(8'(i));
            r1_ce = 1; r1 = empty_n1;
            if (i >= 2 && !empty_n1) stalls++;
            tick();
            if (int'(cnt1) > maxc) maxc = int'(cnt1);
        end
        w1 = 0;
        for (int k = 0; k < 10; k++) begin
            r1 = empty_n1;
            if (!empty_n1) break;
            tick();
        end
        r1 = 0;
        check("stream_stalls", stalls, 0);
        check("stream_max_cnt", maxc, 2);
        check("stream_empty_n1", int'(empty_n1), 0);
        check("stream_q1_left", q1.size(), 0);

        // Reset mid-stream on both FIFOs
        for (int i = 0; i < 3; i++) begin
            w0_ce = 1; w0 = 1; din0 = 8'(8'h31 + i); q0.push_back(8'(8'h31 + i));
            w1_ce = 1; w1 = 1; din1 = 8'(8'h31 + i); q1.push_back(8'(8'h31 + i));
            tick();
        end
        w0 = 0; w1 = 0;
        check("cnt0_pre_rst", int'(cnt0), 3);
        check("cnt1_pre_rst", int'(cnt1), 3);
        reset = 1;
        w0 = 1; w1 = 1; din0 = 8'h55; din1 = 8'h55;
        r0_ce = 1; r0 = 1; r1_ce = 1; r1 = 1;
        q0.delete(); q1.delete();
        tick();
        reset = 0;
        w0 = 0; w1 = 0; r0 = 0; r1 = 0;
        check("cnt0_mid_rst", int'(cnt0), 0);
        check("empty_n0_mid_rst", int'(empty_n0), 0);
        check("cnt1_mid_rst", int'(cnt1), 0);
        check("empty_n1_mid_rst", int'(empty_n1), 0);

        w0 = 1; din0 = 8'h7; q0.push_back(8'h7);
        w1 = 1; din1 = 8'h7; q1.push_back(8'h7);
        tick();
        w0 = 0; w1 = 0;
        check("lat0_1cyc", int'(empty_n0), 1);
        check("lat1_1cyc", int'(empty_n1), 0);
        tick();
        check("lat1_2cyc", int'(empty_n1), 1);
        r0 = 1; r1 = 1;
        tick();
        r0 = 0; r1 = 0;
        check("empty_n0_final", int'(empty_n0), 0);
        check("empty_n1_final", int'(empty_n1), 0);
        tick(); tick();
        check("q0_left", q0.size(), 0);
        check("q1_left", q1.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
